// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, parity-type constants and
// small bit helpers used by both the receiver and the transmitter.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the line must carry, given the XOR of the data bits.
    function automatic logic parity_of(input logic data_xor, input logic typ);
        return (typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and frame configuration in, decoded
// word and status pulses out.
interface uart_rx_if #(parameter int DATA_WIDTH = 8);

    // DATA_VALID/PAR_ERR/STP_ERR are single-cycle pulses with no ready/backpressure:
    // the consumer must take P_DATA on the DATA_VALID cycle; P_DATA then holds until
    // the next good frame.
    logic                  RX_IN;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Bit-period counter plus 3-sample majority voter. sample_tick marks the last
// sample count; the consumer registers bit_val there so it is held from PRESCALE/2+2.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic run,
    input  logic rx,
    output logic sample_tick,
    output logic bit_val
);

    localparam int CW   = $clog2(PRESCALE);
    localparam int HALF = PRESCALE / 2;

    logic [CW-1:0] cnt;
    logic          s_lo;
    logic          s_mid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt   <= '0;
            s_lo  <= 1'b1;
            s_mid <= 1'b1;
        end else begin
            if (!run || cnt == CW'(PRESCALE - 1)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CW'(HALF - 1)) s_lo  <= rx;
            if (cnt == CW'(HALF))     s_mid <= rx;
        end
    end

    // Third sample is the live line value at count PRESCALE/2+1.
    assign sample_tick = (cnt == CW'(HALF + 1));
    assign bit_val     = maj3(s_lo, s_mid, rx);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, LSB-first shift register and
// parity/stop checks; bit timing comes from uart_rx_sampler.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.slave  rx_if,
    output rx_state_t dbg_state
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rx_s1, rx_s2;
    rx_state_t             state;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_q, par_typ_q, par_err_q, armed;
    logic                  data_valid_q, par_err_o, stp_err_o;
    logic                  sample_tick, bit_val, start_det, frame_end, cnt_run;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_if.RX_IN;
            rx_s2 <= rx_s1;
        end
    end

    // armed blocks a line stuck low after a stop error from looking like a new start.
    assign start_det = (state == ST_IDLE) && armed && !rx_s2;
    assign frame_end = sample_tick && ((state == ST_STOP) || (state == ST_START && bit_val));
    assign cnt_run   = (state == ST_IDLE) ? start_det : !frame_end;

    uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
        .CLK         (CLK),
        .RST         (RST),
        .run         (cnt_run),
        .rx          (rx_s2),
        .sample_tick (sample_tick),
        .bit_val     (bit_val)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_err_q    <= 1'b0;
            armed        <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_o    <= 1'b0;
            stp_err_o    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_o    <= 1'b0;
            stp_err_o    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_s2) armed <= 1'b1;
                    if (start_det) begin
                        state     <= ST_START;
                        par_en_q  <= rx_if.PAR_EN;
                        par_typ_q <= rx_if.PAR_TYP;
                        par_err_q <= 1'b0;
                        bit_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (sample_tick) state <= bit_val ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (sample_tick) begin
                        shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_tick) begin
                        par_err_q <= (bit_val != parity_of(^shift_q, par_typ_q));
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Frame ends at the stop-bit sample point, not at the full bit.
                    if (sample_tick) begin
                        state     <= ST_IDLE;
                        par_err_o <= par_err_q;
                        stp_err_o <= !bit_val;
                        if (!bit_val) armed <= 1'b0;
                        if (bit_val && !par_err_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.DATA_VALID = data_valid_q;
    assign rx_if.PAR_ERR    = par_err_o;
    assign rx_if.STP_ERR    = stp_err_o;
    assign dbg_state        = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table, hand-written corner sequences
// and random frames, all checked through an expected-pulse queue.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int PRESCALE = 8;
    localparam int DW       = 8;
    localparam int EW       = DW + 3;

    logic      CLK;
    logic      RST;
    rx_state_t dbg_state;

    uart_rx_if #(.DATA_WIDTH(DW)) u ();

    uart_rx #(.PRESCALE(PRESCALE), .DATA_WIDTH(DW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_if     (u),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    // Expected pulse record: {DATA_VALID, PAR_ERR, STP_ERR, P_DATA}
    logic [EW-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] last_good = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic sample_outputs();
        logic [EW-1:0] got;
        if (RST && (u.DATA_VALID || u.PAR_ERR || u.STP_ERR)) begin
            got = {u.DATA_VALID, u.PAR_ERR, u.STP_ERR, u.P_DATA};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL frame_out: unexpected pulse got %h, required none", got);
            end else begin
                check("frame_out", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // One clock: sample on the falling edge, return just after the rising edge.
    task automatic tick();
        @(negedge CLK);
        sample_outputs();
        @(posedge CLK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- drivers ----------------
    task automatic drive_bit(input logic b, input logic spike);
        for (int c = 0; c < PRESCALE; c++) begin
            u.RX_IN = (spike && c == PRESCALE / 2) ? ~b : b;
            tick();
        end
    endtask

    task automatic send_frame(input logic [DW-1:0] data, input logic pe, input logic pt,
                              input logic pb, input logic stop, input int spike_bit,
                              input logic flip, input int tail_low);
        u.PAR_EN  = pe;
        u.PAR_TYP = pt;
        drive_bit(1'b0, 1'b0);
        if (flip) begin
            u.PAR_EN  = ~pe;
            u.PAR_TYP = ~pt;
        end
        for (int i = 0; i < DW; i++) drive_bit(data[i], spike_bit == i);
        if (pe) drive_bit(pb, 1'b0);
        drive_bit(stop, 1'b0);
        for (int i = 0; i < tail_low; i++) drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b1, 1'b0);
    endtask

    function automatic logic [EW-1:0] pack_exp(input logic v, input logic pe, input logic se,
                                              input logic [DW-1:0] d);
        return {v, pe, se, d};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic          par_en;
        logic          par_typ;
        logic          par_bit;
        logic          stop_bit;
        int            spike_bit;
        logic          flip_cfg;
        logic          exp_valid;
        logic          exp_par_err;
        logic          exp_stp_err;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [DW-1:0] d;
        logic          pe, pt, pb;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h03};
        vecs[2] = '{8'h03, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h03};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80};
        vecs[6] = '{8'h7E, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h80};
        vecs[7] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1,  3, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC3};
        vecs[8] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};

        // ---- reset ----
        RST       = 1'b0;
        u.RX_IN   = 1'b1;
        u.PAR_EN  = 1'b0;
        u.PAR_TYP = 1'b0;
        ticks(3);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_p_data", u.P_DATA, 0);
        check("rst_pulses", {u.DATA_VALID, u.PAR_ERR, u.STP_ERR}, 0);
        RST = 1'b1;
        ticks(4);
        check("post_rst_state", dbg_state, ST_IDLE);

        // ---- table ----
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(pack_exp(vecs[i].exp_valid, vecs[i].exp_par_err,
                                     vecs[i].exp_stp_err, vecs[i].exp_data));
            send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].par_bit,
                       vecs[i].stop_bit, vecs[i].spike_bit, vecs[i].flip_cfg, 0);
            check("table_drain", exp_q.size(), 0);
            exp_q.delete();
        end
        last_good = 8'h01;

        // ---- 2-cycle low glitch on an idle line ----
        u.RX_IN = 1'b0;
        ticks(2);
        u.RX_IN = 1'b1;
        tick();
        check("glitch_start", dbg_state, ST_START);
        ticks(2 * PRESCALE);
        check("glitch_idle", dbg_state, ST_IDLE);

        // ---- stop error then line held low for 20 bits ----
        exp_q.push_back(pack_exp(1'b0, 1'b0, 1'b1, last_good));
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 20);
        check("held_low_drain", exp_q.size(), 0);
        check("held_low_idle", dbg_state, ST_IDLE);
        exp_q.delete();

        // ---- random good frames ----
        for (int i = 0; i < 6; i++) begin
            d  = DW'($urandom_range(0, 255));
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            pb = (^d) ^ pt;
            exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, d));
            send_frame(d, pe, pt, pb, 1'b1, -1, 1'b0, 0);
            check("rand_drain", exp_q.size(), 0);
            exp_q.delete();
            last_good = d;
        end

        // ---- reset during data bit 4, then a clean frame ----
        u.PAR_EN = 1'b0;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        u.RX_IN = 1'b0;
        ticks(3);
        RST = 1'b0;
        #1;
        check("midrst_state", dbg_state, ST_IDLE);
        check("midrst_p_data", u.P_DATA, 0);
        u.RX_IN = 1'b1;
        ticks(3);
        RST = 1'b1;
        ticks(2 * PRESCALE);
        check("midrst_quiet", exp_q.size(), 0);
        exp_q.push_back(pack_exp(1'b1, 1'b0, 1'b0, 8'h3C));
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0, 0);
        check("midrst_drain", exp_q.size(), 0);
        check("midrst_p_data_final", u.P_DATA, 32'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL expose parameter PRESCALE, default 8, clock cycles per bit period (even, 4..32).
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 8, data bits per frame.
REQ-003 Port CLK  input  1  single clock, rising edge.
REQ-004 Port RST  input  1  reset, asynchronous, active-low.
REQ-005 Port RX_IN  input  1  serial line, idle high, asynchronous to CLK.
REQ-006 Port PAR_EN  input  1  1 = frame carries a parity bit.
REQ-007 Port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-008 Port P_DATA  output  DATA_WIDTH  last received data word, LSB first on the line.
REQ-009 Port DATA_VALID  output  1  one-cycle pulse, P_DATA holds a good frame.
REQ-010 Port PAR_ERR  output  1  one-cycle pulse, parity mismatch.
REQ-011 Port STP_ERR  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-012 RX_IN SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value only.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE -> START SHALL occur on the first cycle the synchronized line is 0; the bit-cycle counter clears to 0 on that cycle.
REQ-015 Within each bit, the counter SHALL run 0..PRESCALE-1 and then wrap to 0, advancing the bit.
REQ-016 The bit value SHALL be the majority of samples at counts PRESCALE/2-1, PRESCALE/2, and PRESCALE/2+1, and SHALL be registered at count PRESCALE/2+2.
REQ-017 In START, a sampled 1 SHALL abort to IDLE with no outputs pulsed (glitch rejection).
REQ-018 In DATA, bits SHALL shift in LSB first; after DATA_WIDTH bits, go to PARITY if PAR_EN, else STOP.
REQ-019 PARITY SHALL compare the sampled bit with the XOR of the data bits, inverted when PAR_TYP=1.
REQ-020 STOP SHALL end at its sample point (count PRESCALE/2+2), not at the full bit, then go to IDLE; a new start edge is accepted from the next cycle.
REQ-021 At STOP end, with stop=1 and no parity error: P_DATA updates and DATA_VALID pulses for exactly one cycle.
REQ-022 At STOP end, with a parity error: PAR_ERR pulses, DATA_VALID stays 0, and P_DATA keeps its previous value.
REQ-023 At STOP end, with stop=0: STP_ERR pulses and DATA_VALID stays 0; PAR_ERR pulses in the same cycle if parity also failed.
REQ-024 PAR_EN and PAR_TYP SHALL be captured at START entry; changes mid-frame have no effect until the next frame.
REQ-025 A line held at 0 after a stop error SHALL NOT retrigger until a 1 has been seen in IDLE.

Reset
REQ-026 RST low SHALL asynchronously force: state IDLE, counters 0, P_DATA 0, DATA_VALID/PAR_ERR/STP_ERR 0, synchronizer flops 1.
REQ-027 Reset asserted mid-frame SHALL discard the frame with no pulse; reception restarts on the first falling edge after release.

Structure
REQ-028 The FSM state encoding and the parity-type constants (EVEN=0, ODD=1) SHALL live in a shared UART include/package, also used by the transmitter.
REQ-029 The 3-sample majority voter plus sample-point counter SHALL be one sub-module, uart_rx_sampler; the FSM, shift register, and checks stay in uart_rx.

Verification
REQ-030 PRESCALE=8, PAR_EN=0, send 0xA5 with stop=1 -> one DATA_VALID pulse, P_DATA=0xA5, no errors.
REQ-031 PAR_EN=1, PAR_TYP=0, send 0x03 with parity 0 -> DATA_VALID; repeat with parity 1 -> PAR_ERR pulse, P_DATA stays 0x03.
REQ-032 PAR_TYP=1, send 0x00 with parity 1 -> DATA_VALID, P_DATA=0x00.
REQ-033 Send 0x5A with stop=0 -> STP_ERR pulse, no DATA_VALID; hold line low 20 bits then idle -> no extra frame.
REQ-034 Drive a 2-cycle low glitch on idle line -> FSM returns to IDLE, no pulses; a single-cycle spike at sample count PRESCALE/2 within a data bit -> bit value unchanged.
REQ-035 Assert RST during data bit 4 of a frame, release, then send 0x3C -> no pulse for the aborted frame; P_DATA=0x3C with DATA_VALID.
